// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA rectangle renderer: opcodes,
// parser states and the rectangle slot record.
package vga_pkg;

  localparam int COLOUR_W = 6;

  localparam logic [1:0] OP_NOP      = 2'b00;
  localparam logic [1:0] OP_SET_RECT = 2'b01;
  localparam logic [1:0] OP_SET_BG   = 2'b10;
  localparam logic [1:0] OP_CLEAR    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_P4   = 3'd5,
    ST_PBG  = 3'd6
  } parser_state_t;

  typedef struct packed {
    logic [7:0]          x0;
    logic [7:0]          y0;
    logic [7:0]          x1;
    logic [7:0]          y1;
    logic [COLOUR_W-1:0] colour;
    logic                en;
  } rect_t;

endpackage

// File: rtl/vga_rect_renderer_if.sv
// Byte-wide command channel into the renderer; the producer drives the
// window enable, valid and data, the renderer reports ready and busy.
interface vga_rect_renderer_if;

  logic       cmd_en;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       cmd_busy;

  modport master (
    output cmd_en,
    output cmd_valid,
    output cmd_data,
    input  cmd_ready,
    input  cmd_busy
  );

  modport slave (
    input  cmd_en,
    input  cmd_valid,
    input  cmd_data,
    output cmd_ready,
    output cmd_busy
  );

endinterface

// File: rtl/vga_rect_renderer_rect_hit.sv
// Single-slot tile comparator: inclusive unsigned bounds on both axes, so an
// inverted rectangle (x0>x1 or y0>y1) can never match.
module rect_hit
  import vga_pkg::*;
(
  input  rect_t      rect,
  input  logic [7:0] tile_x,
  input  logic [7:0] tile_y,
  output logic       hit
);

  logic in_x_s;
  logic in_y_s;

  assign in_x_s = (tile_x >= rect.x0) && (tile_x <= rect.x1);
  assign in_y_s = (tile_y >= rect.y0) && (tile_y <= rect.y1);
  assign hit    = rect.en && in_x_s && in_y_s;

endmodule

// File: rtl/vga_rect_renderer.sv
// Pixel stage behind the VGA timing generator: parses rectangle/background
// commands during blanking and paints registered RGB with matched syncs.
module vga_rect_renderer
  import vga_pkg::*;
#(
  parameter int NUM_RECTS  = 4,
  parameter int TILE_SHIFT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                h_sync,
  input  logic                v_sync,
  input  logic [9:0]          row_counter,
  input  logic [9:0]          col_counter,
  input  logic                screen_inactive,
  vga_rect_renderer_if.slave  cmd,
  output logic [COLOUR_W-1:0] rgb,
  output logic                h_sync_o,
  output logic                v_sync_o
);

  localparam int IDX_W = $clog2(NUM_RECTS);

  parser_state_t       state_r;
  parser_state_t       next_state_s;
  logic                xfer_s;
  logic [1:0]          op_s;
  logic [IDX_W-1:0]    idx_r;
  logic [7:0]          stage_x0_r;
  logic [7:0]          stage_y0_r;
  logic [7:0]          stage_x1_r;
  logic [7:0]          stage_y1_r;
  rect_t               slots_r [NUM_RECTS];
  logic [COLOUR_W-1:0] bg_r;
  logic [7:0]          tile_x_s;
  logic [7:0]          tile_y_s;
  logic [NUM_RECTS-1:0] hit_s;
  logic [COLOUR_W-1:0] pick_s;

  // Commands only flow inside the blanking window; there is no other stall.
  assign cmd.cmd_ready = cmd.cmd_en;
  assign xfer_s        = cmd.cmd_valid && cmd.cmd_en;
  assign op_s          = cmd.cmd_data[7:6];
  assign cmd.cmd_busy  = (state_r != ST_IDLE);

  // Parser state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Parser next state; without a transfer the state simply holds.
  always_comb begin
    next_state_s = state_r;
    if (xfer_s) begin
      case (state_r)
        ST_IDLE: begin
          case (op_s)
            OP_SET_RECT: next_state_s = ST_P0;
            OP_SET_BG:   next_state_s = ST_PBG;
            default:     next_state_s = ST_IDLE;
          endcase
        end
        ST_P0:   next_state_s = ST_P1;
        ST_P1:   next_state_s = ST_P2;
        ST_P2:   next_state_s = ST_P3;
        ST_P3:   next_state_s = ST_P4;
        ST_P4:   next_state_s = ST_IDLE;
        ST_PBG:  next_state_s = ST_IDLE;
        default: next_state_s = ST_IDLE;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // Staging, slot table and background; a slot is only written whole on its
  // colour byte, so the pixel path never sees half-updated geometry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r      <= '0;
      stage_x0_r <= 8'd0;
      stage_y0_r <= 8'd0;
      stage_x1_r <= 8'd0;
      stage_y1_r <= 8'd0;
      bg_r       <= '0;
      for (int i = 0; i < NUM_RECTS; i++) begin
        slots_r[i] <= '0;
      end
    end else if (xfer_s) begin
      case (state_r)
        ST_IDLE: begin
          idx_r <= cmd.cmd_data[IDX_W-1:0];
          if (op_s == OP_CLEAR) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
              slots_r[i].en <= 1'b0;
            end
          end
        end
        ST_P0:  stage_x0_r <= cmd.cmd_data;
        ST_P1:  stage_y0_r <= cmd.cmd_data;
        ST_P2:  stage_x1_r <= cmd.cmd_data;
        ST_P3:  stage_y1_r <= cmd.cmd_data;
        ST_P4: begin
          slots_r[idx_r] <= '{x0:     stage_x0_r,
                              y0:     stage_y0_r,
                              x1:     stage_x1_r,
                              y1:     stage_y1_r,
                              colour: cmd.cmd_data[COLOUR_W-1:0],
                              en:     1'b1};
        end
        ST_PBG: bg_r <= cmd.cmd_data[COLOUR_W-1:0];
        default: ;
      endcase
    end
  end

  assign tile_x_s = 8'(col_counter >> TILE_SHIFT);
  assign tile_y_s = 8'(row_counter >> TILE_SHIFT);

  for (genvar g = 0; g < NUM_RECTS; g++) begin : g_hit
    rect_hit u_rect_hit (
      .rect   (slots_r[g]),
      .tile_x (tile_x_s),
      .tile_y (tile_y_s),
      .hit    (hit_s[g])
    );
  end

  // Priority mux: walk from the highest slot down so the lowest hit wins.
  always_comb begin
    pick_s = bg_r;
    for (int i = NUM_RECTS - 1; i >= 0; i--) begin
      pick_s = hit_s[i] ? slots_r[i].colour : pick_s;
    end
  end

  // Output register: colour and both syncs share one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb      <= '0;
      h_sync_o <= 1'b1;
      v_sync_o <= 1'b1;
    end else begin
      rgb      <= screen_inactive ? '0 : pick_s;
      h_sync_o <= h_sync;
      v_sync_o <= v_sync;
    end
  end

endmodule

// File: tb/tb_vga_rect_renderer.sv
// Randomised bench for vga_rect_renderer against a command-list/tile-arithmetic
// model, with directed literal checks for the key scenarios.
module tb_vga_rect_renderer;

  logic       clk;
  logic       rst_n;
  logic       h_sync;
  logic       v_sync;
  logic [9:0] row;
  logic [9:0] col;
  logic       screen_inactive;
  logic [5:0] rgb;
  logic       h_sync_o;
  logic       v_sync_o;

  int checks = 0;
  int errors = 0;

  vga_rect_renderer_if cmd_bus ();

  vga_rect_renderer #(.NUM_RECTS(4), .TILE_SHIFT(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .h_sync          (h_sync),
    .v_sync          (v_sync),
    .row_counter     (row),
    .col_counter     (col),
    .screen_inactive (screen_inactive),
    .cmd             (cmd_bus.slave),
    .rgb             (rgb),
    .h_sync_o        (h_sync_o),
    .v_sync_o        (v_sync_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bytes of the command in progress plus decoded scene.
  logic [7:0] pend[$];
  int         m_x0[4], m_y0[4], m_x1[4], m_y1[4];
  logic [5:0] m_col[4];
  bit         m_en[4];
  logic [5:0] m_bg;

  function automatic void model_reset();
    pend.delete();
    for (int i = 0; i < 4; i++) begin
      m_en[i] = 1'b0; m_x0[i] = 0; m_y0[i] = 0; m_x1[i] = 0; m_y1[i] = 0; m_col[i] = 6'd0;
    end
    m_bg = 6'd0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] opb;
    int need;
    pend.push_back(b);
    opb = pend[0];
    case (opb[7:6])
      2'b01:   need = 6;
      2'b10:   need = 2;
      default: need = 1;
    endcase
    if (pend.size() == need) begin
      int idx;
      logic [7:0] cb;
      idx = int'(opb[1:0]);
      if (opb[7:6] == 2'b11) begin
        for (int i = 0; i < 4; i++) m_en[i] = 1'b0;
      end else if (opb[7:6] == 2'b10) begin
        cb = pend[1];
        m_bg = cb[5:0];
      end else if (opb[7:6] == 2'b01) begin
        m_x0[idx] = int'(pend[1]);
        m_y0[idx] = int'(pend[2]);
        m_x1[idx] = int'(pend[3]);
        m_y1[idx] = int'(pend[4]);
        cb = pend[5];
        m_col[idx] = cb[5:0];
        m_en[idx] = 1'b1;
      end
      pend.delete();
    end
  endfunction

  function automatic logic [5:0] model_pix(input logic [9:0] c, input logic [9:0] r, input logic inact);
    int tx, ty;
    tx = int'(c) / 4;
    ty = int'(r) / 4;
    if (inact) return 6'd0;
    for (int i = 0; i < 4; i++) begin
      if (m_en[i] && tx >= m_x0[i] && tx <= m_x1[i] && ty >= m_y0[i] && ty <= m_y1[i])
        return m_col[i];
    end
    return m_bg;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask

  // Per-cycle compare against the model.
  always @(posedge clk) begin : compare
    logic [5:0] e_rgb;
    logic       e_hs, e_vs, e_en, e_busy;
    if (!rst_n) begin
      model_reset();
      e_rgb = 6'd0; e_hs = 1'b1; e_vs = 1'b1;
    end else begin
      e_rgb = model_pix(col, row, screen_inactive);
      e_hs  = h_sync;
      e_vs  = v_sync;
      if (cmd_bus.cmd_valid && cmd_bus.cmd_en) model_byte(cmd_bus.cmd_data);
    end
    e_en   = cmd_bus.cmd_en;
    e_busy = (pend.size() != 0);
    #1;
    check("rgb", {2'b00, rgb}, {2'b00, e_rgb});
    check("h_sync_o", {7'd0, h_sync_o}, {7'd0, e_hs});
    check("v_sync_o", {7'd0, v_sync_o}, {7'd0, e_vs});
    check("cmd_ready", {7'd0, cmd_bus.cmd_ready}, {7'd0, e_en});
    check("cmd_busy", {7'd0, cmd_bus.cmd_busy}, {7'd0, e_busy});
  end

  task automatic drive(input logic en, input logic valid, input logic [7:0] data);
    @(negedge clk);
    cmd_bus.cmd_en    = en;
    cmd_bus.cmd_valid = valid;
    cmd_bus.cmd_data  = data;
    col             = 10'($urandom_range(0, 1023));
    row             = 10'($urandom_range(0, 1023));
    screen_inactive = 1'($urandom_range(0, 1));
    h_sync          = 1'($urandom_range(0, 1));
    v_sync          = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b1, 1'b1, b);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 8'($urandom));
  endtask

  task automatic probe(input string name, input logic [9:0] c, input logic [9:0] r,
                       input logic inact, input logic [5:0] want);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
    col = c; row = r; screen_inactive = inact;
    @(posedge clk);
    #2;
    check(name, {2'b00, rgb}, {2'b00, want});
  endtask

  task automatic sweep_row(input logic [9:0] r, input int c_lo, input int c_hi);
    for (int c = c_lo; c <= c_hi; c++) begin
      @(negedge clk);
      cmd_bus.cmd_valid = 1'b0;
      col = 10'(c); row = r; screen_inactive = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    h_sync = 1'b0; v_sync = 1'b0;
    row = 10'd0; col = 10'd0; screen_inactive = 1'b0;
    cmd_bus.cmd_en = 1'b1; cmd_bus.cmd_valid = 1'b0; cmd_bus.cmd_data = 8'd0;
    model_reset();

    // Reset held with counters running.
    repeat (8) begin
      @(negedge clk);
      col = col + 10'd1; row = row + 10'd3; h_sync = 1'b0; v_sync = 1'b0;
    end
    @(posedge clk); #2;
    check("reset_rgb", {2'b00, rgb}, 8'h00);
    check("reset_hsync", {7'd0, h_sync_o}, 8'h01);
    check("reset_vsync", {7'd0, v_sync_o}, 8'h01);
    check("reset_busy", {7'd0, cmd_bus.cmd_busy}, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    probe("post_reset_bg0", 10'd100, 10'd100, 1'b0, 6'h00);

    // Background colour.
    send(8'h80); send(8'h2A); idle(2);
    probe("bg_visible", 10'd300, 10'd200, 1'b0, 6'h2A);
    probe("bg_inactive", 10'd300, 10'd200, 1'b1, 6'h00);

    // Rectangle 0: tiles x 10..20, y 5..8 -> cols 40..83, rows 20..35.
    send(8'h40); send(8'd10); send(8'd5); send(8'd20); send(8'd8); send(8'h30); idle(1);
    probe("rect_in", 10'd40, 10'd20, 1'b0, 6'h30);
    probe("rect_corner", 10'd83, 10'd35, 1'b0, 6'h30);
    probe("rect_left_edge", 10'd39, 10'd20, 1'b0, 6'h2A);
    probe("rect_right_edge", 10'd84, 10'd20, 1'b0, 6'h2A);
    probe("rect_below", 10'd50, 10'd36, 1'b0, 6'h2A);
    sweep_row(10'd19, 30, 90);
    sweep_row(10'd20, 30, 90);
    sweep_row(10'd35, 30, 90);
    sweep_row(10'd36, 30, 90);

    // Rectangle 1 overlaps; slot 0 keeps priority. CLEAR removes both.
    send(8'h41); send(8'd10); send(8'd5); send(8'd20); send(8'd8); send(8'h0C); idle(1);
    probe("prio_overlap", 10'd60, 10'd28, 1'b0, 6'h30);
    send(8'hC0); idle(1);
    probe("clear_bg", 10'd60, 10'd28, 1'b0, 6'h2A);

    // Split command across blanking windows.
    send(8'h42); send(8'd1); send(8'd1);
    repeat (100) drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    @(posedge clk); #2;
    check("split_ready", {7'd0, cmd_bus.cmd_ready}, 8'h00);
    check("split_busy", {7'd0, cmd_bus.cmd_busy}, 8'h01);
    probe("split_not_visible", 10'd8, 10'd8, 1'b0, 6'h2A);
    send(8'd3); send(8'd3); send(8'h03); idle(1);
    probe("split_visible", 10'd8, 10'd8, 1'b0, 6'h03);
    probe("split_edge", 10'd16, 10'd8, 1'b0, 6'h2A);

    // Degenerate: x0 > x1 never hits.
    send(8'h43); send(8'd50); send(8'd0); send(8'd49); send(8'd255); send(8'h15); idle(1);
    probe("degenerate", 10'd198, 10'd100, 1'b0, 6'h2A);
    sweep_row(10'd100, 0, 1023);

    // Randomised traffic, then a reset in the middle of it, then more.
    repeat (3000) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    repeat (5) begin
      drive(1'b1, 1'b1, 8'($urandom));
      rst_n = 1'b0;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2000) drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_rect_renderer.md
Name: vga_rect_renderer

Overview:
- Pixel stage directly downstream of tt_um_emern_vga. Consumes its h_sync, v_sync, row_counter, col_counter, screen_inactive and cmd_en.
- Accepts a byte-wide command stream, but only while cmd_en is high (blanking). The commands define NUM_RECTS coloured rectangles and a background colour.
- During active video it produces registered 6-bit RGB per pixel, plus syncs delayed to match the RGB latency.

Parameters:
- NUM_RECTS, 4, number of rectangle slots; power of two; fixed at 4 for this revision.
- TILE_SHIFT, 2, coordinate granularity; rectangle coordinates are in units of 2^TILE_SHIFT pixels.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- h_sync  in  1  horizontal sync from the timing stage
- v_sync  in  1  vertical sync from the timing stage
- row_counter  in  10  current row
- col_counter  in  10  current column
- screen_inactive  in  1  high outside the visible area
- cmd_en  in  1  high when command writes are permitted
- cmd_valid  in  1  cmd_data is presented
- cmd_data  in  8  command byte
- cmd_ready  out  1  byte accepted this cycle when cmd_valid && cmd_ready
- cmd_busy  out  1  parser is mid-command
- rgb  out  6  {R[1:0],G[1:0],B[1:0]}, registered
- h_sync_o  out  1  h_sync delayed 1 cycle
- v_sync_o  out  1  v_sync delayed 1 cycle

Behaviour:
- Reset (asynchronous, rst_n low):
  - rgb=0, h_sync_o=1, v_sync_o=1.
  - All rect enable bits=0, bg colour=0.
  - Parser in IDLE; cmd_busy=0.
- cmd_ready = cmd_en. No other stall source. A byte transfers on the clk edge where cmd_valid && cmd_en.
- Opcode byte encoding: [7:6]=op, [1:0]=rect index, [5:2] ignored.
  - op 00 NOP: no payload.
  - op 01 SET_RECT: 5 payload bytes, in order x0, y0, x1, y1, colour[5:0].
  - op 10 SET_BG: 1 payload byte, colour[5:0].
  - op 11 CLEAR: no payload; clears every enable bit. Geometry is kept.
- Parser FSM states and transitions:
  - IDLE: NOP and CLEAR execute on acceptance and stay in IDLE. SET_RECT latches the index and goes to P0. SET_BG goes to PBG.
  - P0..P3: capture x0, y0, x1, y1 into a staging register, advancing one state per accepted byte.
  - P4: capture the colour byte. On acceptance, commit the staging register plus colour to slot[index], set its enable, return to IDLE.
  - PBG: on acceptance, write the bg colour and return to IDLE.
  - The slot is never partially written; the commit is atomic on the final byte.
- cmd_busy=1 in any state other than IDLE.
- cmd_en falling mid-command: the parser holds its state and staging data. It resumes on the next cmd_en window with no timeout.
- Pixel path:
  - tile_x = col_counter>>TILE_SHIFT (8 bits); tile_y = row_counter>>TILE_SHIFT (8 bits).
  - Hit[i] = enable[i] && x0≤tile_x≤x1 && y0≤tile_y≤y1. Comparison is unsigned and inclusive at both ends.
  - x0>x1 or y0>y1 never hits.
- Colour selection:
  - Priority: the lowest index hit wins. With no hit, the colour is bg.
  - When screen_inactive is high, the colour is 0.
- Latency: rgb, h_sync_o and v_sync_o all register on the same edge, exactly 1 cycle after the inputs.
- A slot commit takes effect on the pixel path the cycle after the commit edge.

Decomposition:
- Shared package vga_pkg:
  - opcode constants OP_NOP/OP_SET_RECT/OP_SET_BG/OP_CLEAR.
  - parser state enum.
  - rect_t struct {x0,y0,x1,y1:8; colour:6; en:1}.
  - COLOUR_W=6.
- One natural sub-module, rect_hit: a combinational single-slot comparator, instantiated NUM_RECTS times, with a priority mux in the parent.

Test Plan:
- Reset mid-frame: hold rst_n low with counters running → rgb=0, h_sync_o=v_sync_o=1, cmd_busy=0. After release with no commands, visible pixels are 0 (bg=0).
- Background: with cmd_en=1, send 0x80,0x2A → visible pixels give rgb=0x2A. With screen_inactive=1, rgb=0. Delayed syncs equal the inputs from the prior cycle.
- Rect and boundary, part 1: send SET_RECT 0x40,10,5,20,8,0x30 → rect 0 is enabled.
- Rect and boundary, part 2: col 40..83 and row 20..35 give rgb=0x30. Col 39 and col 84 give bg.
- Priority: rect 1 (0x41) covers the same area with colour 0x0C → overlap shows 0x30. After CLEAR (0xC0), every pixel shows bg.
- Split command: send 0x42,1,1 then drop cmd_en for 100 cycles → cmd_ready=0, cmd_busy=1, rect 2 not yet visible. Raise cmd_en and send 3,3,0x03 → rect 2 is visible with colour 0x03 on the next frame.
- Degenerate: SET_RECT with x0=50, x1=49 → rect never hits; bg is shown across the whole row.
